psc_trigger_rx: RTL and testbench

Receive-side stage on the power-supply controller end of the PSC trigger link. Consumes the serial stream from the PSC trigger transmitter: a continuous 100-bit frame, LSB first, one bit per link clock, carrying either the idle pattern (0x5 nibbles) or the trigger pattern (0x6 nibbles). Recovers link status, emits one trigger pulse per trigger burst and counts line errors. It runs in the same 10 MHz link-clock domain as the transmitter.

---
 rtl/psc_link_pkg.sv | 20 ++
 rtl/psc_rx_classifier.sv | 30 +++
 rtl/psc_trigger_rx.sv | 106 ++++++++++
 tb/tb_psc_trigger_rx.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/psc_link_pkg.sv
// psc_link_pkg: link-level types and patterns shared by the PSC trigger transmitter and receiver.
package psc_link_pkg;

   typedef enum logic [1:0] {NO_SIGNAL, IDLE, TRIG_ACTIVE} state_t;
   typedef enum logic [1:0] {CLS_NONE, CLS_IDLE, CLS_TRIG} cls_t;

   localparam int PSC_FRAME_BITS = 100;
   localparam logic [3:0] PSC_IDLE_NIBBLE = 4'h5;
   localparam logic [3:0] PSC_TRIG_NIBBLE = 4'h6;

   // A window can straddle nibbles at any phase, so match every rotation.
   function automatic logic is_rot(input logic [3:0] w, input logic [3:0] n);
      return w == n || w == {n[2:0], n[3]} || w == {n[1:0], n[3:2]} || w == {n[0], n[3:1]};
   endfunction

   function automatic cls_t classify(input logic [3:0] w);
      return is_rot(w, PSC_IDLE_NIBBLE) ? CLS_IDLE : is_rot(w, PSC_TRIG_NIBBLE) ? CLS_TRIG : CLS_NONE;
   endfunction

endpackage

// File: rtl/psc_rx_classifier.sv
// psc_rx_classifier: synchronizes the serial line, keeps a 4-bit window and registers its class.
module psc_rx_classifier
   import psc_link_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic psc_input,
   output cls_t cls,
   output logic edge_det
);

   logic [1:0] sync;
   logic [3:0] w;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync <= '0;
         w    <= '0;
         cls  <= CLS_NONE;
      end else begin
         sync <= {sync[0], psc_input};
         w    <= {w[2:0], sync[1]};
         cls  <= classify(w);
      end
   end

   // w[0] holds the previous synchronized bit
   assign edge_det = sync[1] ^ w[0];

endmodule

// File: rtl/psc_trigger_rx.sv
// psc_trigger_rx: PSC trigger link receiver - link status, one strobe per trigger burst, line-error count.
// Define PSC_RX_FRAME_CHECK_EN to also flag trigger bursts that end off a 100-bit frame boundary.
module psc_trigger_rx
   import psc_link_pkg::*;
#(
   parameter int TRIG_THRESH = 16,
   parameter int IDLE_THRESH = 16,
   parameter int LOS_CYCLES  = 8,
   parameter int ERR_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             psc_input,
   input  logic             err_clr,
   output logic             trig_pulse,
   output logic             trig_active,
   output logic             link_ok,
   output logic [ERR_W-1:0] err_count
);

   localparam int LW = $clog2(LOS_CYCLES + 1);
   localparam logic [6:0] RUN_MAX = 7'd127;
   localparam logic [6:0] TRIG_N = 7'(TRIG_THRESH);
   localparam logic [6:0] IDLE_N = 7'(IDLE_THRESH);
   localparam logic [LW-1:0] LOS_N = LW'(LOS_CYCLES);

   cls_t cls;
   state_t state, state_n;
   logic edge_det, prev_none, los, trig_hit, idle_hit, err_ev, frame_err;
   logic [6:0] trig_run, idle_run, trig_run_n, idle_run_n;
   logic [LW-1:0] los_cnt, los_cnt_n;

   psc_rx_classifier u_cls (
      .clk      (clk),
      .reset    (reset),
      .psc_input(psc_input),
      .cls      (cls),
      .edge_det (edge_det)
   );

   assign trig_run_n = cls == CLS_TRIG ? (trig_run == RUN_MAX ? RUN_MAX : trig_run + 7'd1) : '0;
   assign idle_run_n = cls == CLS_IDLE ? (idle_run == RUN_MAX ? RUN_MAX : idle_run + 7'd1) : '0;
   assign los_cnt_n  = edge_det ? '0 : los_cnt == LOS_N ? los_cnt : los_cnt + LW'(1);
   assign los        = los_cnt_n == LOS_N;
   assign trig_hit   = trig_run_n >= TRIG_N;
   assign idle_hit   = idle_run_n >= IDLE_N;

   // Decisions use the next run value so the strobe lands TRIG_THRESH+4 clocks after the frame edge.
   always_comb begin
      state_n    = state;
      trig_pulse = 1'b0;
      if (los)
         state_n = NO_SIGNAL;
      else if (state == NO_SIGNAL && idle_hit)
         state_n = IDLE;
      else if (state == IDLE && trig_hit) begin
         state_n    = TRIG_ACTIVE;
         trig_pulse = 1'b1;
      end else if (state == TRIG_ACTIVE && idle_hit)
         state_n = IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= NO_SIGNAL;
      else        state <= state_n;
   end

   assign trig_active = state == TRIG_ACTIVE || trig_pulse;
   assign link_ok     = state != NO_SIGNAL;

`ifdef PSC_RX_FRAME_CHECK_EN
   logic [6:0] fcnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         fcnt <= '0;
      else
         fcnt <= (state == IDLE && cls == CLS_TRIG && trig_run == '0) ? 7'd1 :
                 fcnt == 7'(PSC_FRAME_BITS - 1) ? '0 : fcnt + 7'd1;
   end

   assign frame_err = state == TRIG_ACTIVE && cls == CLS_IDLE && idle_run == '0 && fcnt != '0;
`else
   assign frame_err = 1'b0;
`endif

   // Before the link is up the window is still filling, so unclassified windows are not line errors.
   assign err_ev = (state != NO_SIGNAL && cls == CLS_NONE && prev_none) || frame_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         trig_run  <= '0;
         idle_run  <= '0;
         los_cnt   <= '0;
         prev_none <= 1'b0;
         err_count <= '0;
      end else begin
         trig_run  <= trig_run_n;
         idle_run  <= idle_run_n;
         los_cnt   <= los_cnt_n;
         prev_none <= cls == CLS_NONE;
         err_count <= err_clr ? '0 : (err_ev && err_count != '1) ? err_count + ERR_W'(1) : err_count;
      end
   end

endmodule

// File: tb/tb_psc_trigger_rx.sv
// tb_psc_trigger_rx: directed bench for psc_trigger_rx with hand-computed expectations.
module tb_psc_trigger_rx;

   logic clk = 1'b0;
   logic reset, psc_input, err_clr;
   logic trig_pulse, trig_active, link_ok;
   logic [15:0] err_count;
   int n_cmp = 0, n_bad = 0, pulses = 0, act = 0, p0, a0;

   always #5 clk = ~clk;

   psc_trigger_rx #(
      .TRIG_THRESH(16),
      .IDLE_THRESH(16),
      .LOS_CYCLES (8),
      .ERR_W      (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .psc_input  (psc_input),
      .err_clr    (err_clr),
      .trig_pulse (trig_pulse),
      .trig_active(trig_active),
      .link_ok    (link_ok),
      .err_count  (err_count)
   );

   always @(negedge clk) begin
      if (trig_pulse) pulses++;
      if (trig_active) act++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bit_tx(input logic b);
      psc_input = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] n, input int start, input int count);
      for (int i = start; i < start + count; i++) bit_tx(n[i % 4]);
   endtask

   initial begin
      reset = 1'b0;
      psc_input = 1'b0;
      err_clr = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("rst_link_ok", 32'(link_ok), 0);
      chk("rst_trig_active", 32'(trig_active), 0);
      chk("rst_trig_pulse", 32'(trig_pulse), 0);
      chk("rst_err_count", 32'(err_count), 0);
      reset = 1'b1;

      send(4'h5, 0, 24);
      chk("idle_link_up", 32'(link_ok), 1);
      send(4'h5, 0, 16);
      chk("idle_no_pulse", 32'(pulses), 0);
      chk("idle_err", 32'(err_count), 0);
      chk("idle_trig_active", 32'(trig_active), 0);

      p0 = pulses;
      a0 = act;
      send(4'h6, 0, 19);
      chk("pre_pulse", 32'(trig_pulse), 0);
      chk("pre_active", 32'(trig_active), 0);
      send(4'h6, 19, 1);
      chk("pulse_latency", 32'(trig_pulse), 1);
      chk("active_latency", 32'(trig_active), 1);
      send(4'h6, 20, 1);
      chk("pulse_single", 32'(trig_pulse), 0);
      chk("active_hold", 32'(trig_active), 1);
      send(4'h6, 21, 79);
      send(4'h5, 0, 40);
      chk("frame1_pulses", 32'(pulses - p0), 1);
      chk("frame1_active_cycles", 32'(act - a0), 101);
      chk("frame1_err", 32'(err_count), 0);

      p0 = pulses;
      a0 = act;
      send(4'h6, 0, 300);
      send(4'h5, 0, 40);
      chk("frame3_pulses", 32'(pulses - p0), 1);
      chk("frame3_active_cycles", 32'(act - a0), 301);
      chk("frame3_err", 32'(err_count), 0);

      chk("pre_los_link", 32'(link_ok), 1);
      send(4'h0, 0, 7);
      send(4'h5, 0, 20);
      chk("hold7_link", 32'(link_ok), 1);
      send(4'h0, 0, 8);
      send(4'h5, 0, 4);
      chk("hold8_link", 32'(link_ok), 0);
      p0 = pulses;
      send(4'h6, 0, 200);
      chk("nosig_no_pulse", 32'(pulses - p0), 0);
      chk("nosig_link", 32'(link_ok), 0);
      send(4'h5, 0, 40);
      chk("relink", 32'(link_ok), 1);
      chk("relink_no_pulse", 32'(pulses - p0), 0);

      err_clr = 1'b1;
      send(4'h5, 0, 4);
      err_clr = 1'b0;
      chk("err_clear", 32'(err_count), 0);
      send(4'h0, 0, 5);
      send(4'h5, 0, 40);
      chk("inject_err", 32'(err_count), 6);
      chk("inject_link", 32'(link_ok), 1);

      err_clr = 1'b1;
      send(4'h0, 0, 5);
      send(4'h5, 0, 8);
      err_clr = 1'b0;
      send(4'h5, 0, 32);
      chk("clr_priority", 32'(err_count), 0);

      send(4'h8, 0, 70400);
      chk("err_saturate", 32'(err_count), 32'hFFFF);
      chk("sat_link", 32'(link_ok), 1);
      send(4'h5, 0, 40);
      err_clr = 1'b1;
      send(4'h5, 0, 4);
      err_clr = 1'b0;
      chk("sat_clear", 32'(err_count), 0);

      p0 = pulses;
      send(4'h6, 0, 100);
      chk("burst_active", 32'(trig_active), 1);
      send(4'h6, 0, 10);
      reset = 1'b0;
      #1;
      chk("midrst_active", 32'(trig_active), 0);
      chk("midrst_link", 32'(link_ok), 0);
      chk("midrst_pulse", 32'(trig_pulse), 0);
      send(4'h6, 10, 4);
      reset = 1'b1;
      send(4'h6, 14, 86);
      send(4'h6, 0, 100);
      chk("post_rst_no_pulse", 32'(pulses - p0), 1);
      chk("post_rst_link", 32'(link_ok), 0);
      send(4'h5, 0, 40);
      chk("post_rst_relink", 32'(link_ok), 1);
      send(4'h6, 0, 100);
      send(4'h5, 0, 40);
      chk("post_rst_rearm", 32'(pulses - p0), 2);
      chk("post_rst_err", 32'(err_count), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
